// File: rtl/map_trellis_sched.sv
// Sequences one MAP decode frame: forward alpha pass, backward eta pass, result-tag handshake.
// Latency: 2S+2 cycles from accepted start to done pulse with out_ready held high.
// Backpressure: out_ready low with a pending result freezes the backward pass (eta_en=0, addresses held).
// Optional feature: define MAP_SCHED_TERM_EN to add TAIL termination steps to both passes;
// the tail results are computed but never offered downstream, and beta_init then means terminated metrics.
module map_trellis_sched #(
  parameter int K    = 16,
  parameter int AW   = 4,
  parameter int TAIL = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   len,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] gamma_addr,
  output logic          alpha_we,
  output logic [AW-1:0] alpha_waddr,
  output logic [AW-1:0] alpha_raddr,
  output logic          alpha_init,
  output logic          beta_init,
  output logic          eta_en,
  output logic          out_valid,
  output logic [AW-1:0] out_idx,
  input  logic          out_ready
);

`ifdef MAP_SCHED_TERM_EN
  localparam bit TERM_EN = 1'b1;
`else
  localparam bit TERM_EN = 1'b0;
`endif

  // Steps appended after the data steps; zero when termination is off.
  localparam int TAIL_STEPS = TERM_EN ? TAIL : 0;
  // Longest len that still fits data plus tail into the alpha RAM.
  localparam logic [AW:0] LEN_MAX = (AW+1)'(K - TAIL_STEPS);
  localparam logic [AW:0] TAIL_W  = (AW+1)'(TAIL_STEPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FWD,
    S_BWD,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t      state;
  logic [AW:0] t;      // one bit wider than an address so S-1 never wraps at S==K
  logic [AW:0] n;      // latched data length N
  logic [AW:0] s_m1;   // last trellis index of the pass, S-1
  logic [AW:0] t_inc;
  logic [AW:0] t_dec;
  logic        advance;
  logic        eta_fire;

  assign s_m1  = n + TAIL_W - (AW+1)'(1);
  assign t_inc = t + (AW+1)'(1);
  assign t_dec = t - (AW+1)'(1);

  // The backward pass may step only when the result slot is free or being drained this cycle.
  assign advance  = !out_valid || out_ready;
  assign eta_fire = (state == S_BWD) && advance;
  // eta_en must follow out_ready within the same cycle, so it cannot be registered.
  assign eta_en   = eta_fire;

  // Frame sequencer: state, step counter and registered RAM/ROM controls for the next cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      t           <= '0;
      n           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      gamma_addr  <= '0;
      alpha_we    <= 1'b0;
      alpha_waddr <= '0;
      alpha_raddr <= '0;
      alpha_init  <= 1'b0;
      beta_init   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (len == '0 || len > LEN_MAX) begin
              err <= 1'b1;
            end else begin
              n           <= len;
              t           <= '0;
              state       <= S_FWD;
              busy        <= 1'b1;
              alpha_we    <= 1'b1;
              alpha_waddr <= '0;
              gamma_addr  <= '0;
              alpha_init  <= 1'b1;
            end
          end
        end
        S_FWD: begin
          if (t == s_m1) begin
            // Backward pass starts at the same index the forward pass ended on.
            state       <= S_BWD;
            alpha_we    <= 1'b0;
            alpha_init  <= 1'b0;
            alpha_raddr <= t[AW-1:0];
            gamma_addr  <= t[AW-1:0];
            beta_init   <= 1'b1;
          end else begin
            t           <= t_inc;
            alpha_waddr <= t_inc[AW-1:0];
            gamma_addr  <= t_inc[AW-1:0];
            alpha_init  <= 1'b0;
          end
        end
        S_BWD: begin
          if (advance) begin
            beta_init <= 1'b0;
            if (t == '0) begin
              state <= S_FLUSH;
            end else begin
              t           <= t_dec;
              alpha_raddr <= t_dec[AW-1:0];
              gamma_addr  <= t_dec[AW-1:0];
            end
          end
        end
        S_FLUSH: begin
          if (out_valid && out_ready) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Result tag: one-cycle eta latency; tail steps (t>=N) are computed but never offered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else if (eta_fire && (t < n)) begin
      out_valid <= 1'b1;
      out_idx   <= t[AW-1:0];
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
